uart_rx_fifo: RTL

Receive-side byte buffer directly downstream of the UART receiver. Captures each received byte on the receiver's one-cycle done strobe, tagged with the framing-error flag sampled in the same cycle. Presents bytes in order on a ready/valid read port to the host/command logic. Reports occupancy, almost-full, a sticky overflow flag and a saturating count of dropped error bytes.

---
 rtl/uart_rx_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// uart_rx_fifo : byte buffer behind the UART receiver, FWFT ready/valid read side
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12,
  parameter int DROP_ERR    = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     rx_error,
  output logic [7:0]               m_data,
  output logic                     m_err,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     ovf_clear,
  output logic [7:0]               err_drops
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    err_drops_q, err_drops_d;

  logic       push_req;
  logic       drop;
  logic       pop;
  logic       push_acc;
  logic       reject;
  logic [8:0] head;

  assign push_req = rx_done && !((DROP_ERR != 0) && rx_error);
  assign drop     = rx_done && rx_error && (DROP_ERR != 0);
  assign pop      = (count_q != '0) && m_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_acc = push_req && ((count_q != FULL_CNT) || pop);
  assign reject   = push_req && (count_q == FULL_CNT) && !pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    err_drops_d = err_drops_q;

    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (push_acc && !pop)      count_d = count_q + CNT_ONE;
    else if (!push_acc && pop) count_d = count_q - CNT_ONE;

    if (reject)         overflow_d = 1'b1;
    else if (ovf_clear) overflow_d = 1'b0;

    if (drop && (err_drops_q != 8'hFF)) err_drops_d = err_drops_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      err_drops_q <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      err_drops_q <= err_drops_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= {rx_error, rx_data};
  end

  // Storage is never reset, so the head is masked while the FIFO is empty.
  assign head        = mem_q[rd_ptr_q];
  assign m_valid     = (count_q != '0);
  assign m_data      = m_valid ? head[7:0] : 8'h00;
  assign m_err       = m_valid ? head[8]   : 1'b0;
  assign count       = count_q;
  assign almost_full = (count_q >= AFULL_CNT);
  assign overflow    = overflow_q;
  assign err_drops   = err_drops_q;

endmodule

`default_nettype wire
